dff_input_conditioner: RTL

//  Conditions a raw asynchronous level (switch/button/external pin) into a clean,

---
 rtl/dff_input_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dff_input_conditioner.sv
// dff_input_conditioner
// Turns a raw asynchronous level (switch, button, external pin) into a clean,
// clock-synchronous level with single-cycle rise/fall pulses, ready to drive
// the D input of the downstream DFF stage.
//
// Pipeline: SYNC_STAGES-deep synchronizer -> debounce counter FSM -> registered
// level (Q), its registered complement (invQ) and registered edge pulses.
// A change on the synchronized input is accepted only after it has disagreed
// with Q for DEBOUNCE_CYCLES consecutive cycles; any return to Q's value
// discards the partial count. The counter never wraps because it is cleared
// on acceptance, before it could exceed DEBOUNCE_CYCLES-1.
//
// Legal parameters: SYNC_STAGES in 2..4, DEBOUNCE_CYCLES >= 1.
module dff_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic CLK,
   input  logic RST,
   input  logic D_in,
   output logic Q,
   output logic invQ,
   output logic rise,
   output logic fall
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q,  sync_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic                   level_q, level_d;
   logic                   inv_q,   inv_d;
   logic                   rise_q,  rise_d;
   logic                   fall_q,  fall_d;

   logic s_out;
   logic mismatch;
   logic toggle;

   // Synchronizer shift: only the last stage is ever looked at, so any X or
   // metastability on D_in stays inside the chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], D_in};
   end

   assign s_out    = sync_q[SYNC_STAGES-1];
   assign mismatch = (s_out != level_q);

   // All state on the rising clock edge; reset forces a quiet, Q=0 condition
   // so no pulse can appear during reset or on its release.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         inv_q   <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         inv_q   <= inv_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state: leave IDLE on a disagreement (unless a single cycle is enough
   // to accept), fall back to IDLE on a bounce or once the change is accepted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mismatch && !SINGLE) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (!mismatch || (cnt_q == CNT_LAST)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter and output logic: count consecutive disagreeing cycles, flip Q
   // when the run is long enough, and derive the edge pulses from the flip.
   always_comb begin
      cnt_d  = '0;
      toggle = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mismatch) begin
               if (SINGLE) begin
                  toggle = 1'b1;
               end else begin
                  cnt_d = CNT_ONE;
               end
            end
         end
         COUNT: begin
            if (mismatch) begin
               if (cnt_q == CNT_LAST) begin
                  toggle = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            cnt_d  = '0;
            toggle = 1'b0;
         end
      endcase
      level_d = level_q ^ toggle;
      inv_d   = ~(level_q ^ toggle);
      rise_d  = toggle & ~level_q;
      fall_d  = toggle & level_q;
   end

   assign Q    = level_q;
   assign invQ = inv_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule
